// File: rtl/stack_sequencer.sv
// stack_sequencer: sequences stack-machine operations over an external 32-entry
// stack (single clock, synchronous active-high reset).
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   op_valid, op_code,
//   op_data, op_ready        operation request handshake (accepted when both high)
//   done, err, result        completion pulse, rejection flag, registered result
//   stk_push/stk_pop/stk_tos strobes to the stack, at most one high per cycle
//   stk_din, stk_dout        push data (registered) / read data (valid the cycle
//                            after a pop or tos strobe)
module stack_sequencer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic [2:0]        op_code,
  input  logic [DATA_W-1:0] op_data,
  output logic              op_ready,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] result,
  output logic              stk_push,
  output logic              stk_pop,
  output logic              stk_tos,
  output logic [DATA_W-1:0] stk_din,
  input  logic [DATA_W-1:0] stk_dout
);

  localparam logic [2:0] OP_PUSH = 3'b000;
  localparam logic [2:0] OP_POP  = 3'b001;
  localparam logic [2:0] OP_TOS  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_NOT  = 3'b110;
  localparam logic [2:0] OP_DUP  = 3'b111;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_POP_A   = 4'd1;
  localparam logic [3:0] S_CAP_A   = 4'd2;
  localparam logic [3:0] S_CAP_B   = 4'd3;
  localparam logic [3:0] S_TOS_RD  = 4'd4;
  localparam logic [3:0] S_TOS_CAP = 4'd5;
  localparam logic [3:0] S_PUSH    = 4'd6;
  localparam logic [3:0] S_DONE    = 4'd7;
  localparam logic [3:0] S_ERR     = 4'd8;

  logic [3:0]        state_q, state_d;
  logic [2:0]        opc_q, opc_d;
  logic [5:0]        depth_q, depth_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] din_q, din_d;

  function automatic logic is_binary(input logic [2:0] code);
    return (code == OP_ADD) || (code == OP_SUB) || (code == OP_AND);
  endfunction

  // Underflow needs 0/1/2 operands; anything that grows the stack needs room.
  function automatic logic reject(input logic [2:0] code, input logic [5:0] depth);
    logic [5:0] need;
    logic       grows;
    need  = is_binary(code) ? 6'd2 : ((code == OP_PUSH) ? 6'd0 : 6'd1);
    grows = (code == OP_PUSH) || (code == OP_DUP);
    return (depth < need) || (grows && (depth >= 6'd32));
  endfunction

  // a is the first-popped (top) operand, b the one below it.
  function automatic logic [DATA_W-1:0] alu(input logic [2:0] code,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    case (code)
      OP_ADD:  return b + a;
      OP_SUB:  return b - a;
      default: return b & a;
    endcase
  endfunction

  // Strobes and status decode straight from registered state.
  assign op_ready = (state_q == S_IDLE);
  assign done     = (state_q == S_DONE) || (state_q == S_ERR);
  assign err      = (state_q == S_ERR);
  assign stk_push = (state_q == S_PUSH);
  assign stk_pop  = (state_q == S_POP_A) || ((state_q == S_CAP_A) && is_binary(opc_q));
  assign stk_tos  = (state_q == S_TOS_RD);
  assign stk_din  = din_q;
  assign result   = result_q;

  always_comb begin
    state_d  = state_q;
    opc_d    = opc_q;
    depth_d  = depth_q;
    a_d      = a_q;
    result_d = result_q;
    din_d    = din_q;

    if (stk_push)     depth_d = depth_q + 6'd1;
    else if (stk_pop) depth_d = depth_q - 6'd1;

    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          opc_d = op_code;
          if (reject(op_code, depth_q)) begin
            state_d = S_ERR;
          end else if (op_code == OP_PUSH) begin
            din_d   = op_data;
            state_d = S_PUSH;
          end else if ((op_code == OP_TOS) || (op_code == OP_DUP)) begin
            state_d = S_TOS_RD;
          end else begin
            state_d = S_POP_A;
          end
        end
      end
      S_POP_A: state_d = S_CAP_A;
      S_CAP_A: begin
        a_d = stk_dout;
        if (opc_q == OP_POP) begin
          result_d = stk_dout;
          state_d  = S_DONE;
        end else if (opc_q == OP_NOT) begin
          din_d   = ~stk_dout;
          state_d = S_PUSH;
        end else begin
          state_d = S_CAP_B;
        end
      end
      S_CAP_B: begin
        din_d   = alu(opc_q, a_q, stk_dout);
        state_d = S_PUSH;
      end
      S_TOS_RD: state_d = S_TOS_CAP;
      S_TOS_CAP: begin
        if (opc_q == OP_TOS) begin
          result_d = stk_dout;
          state_d  = S_DONE;
        end else begin
          din_d   = stk_dout;
          state_d = S_PUSH;
        end
      end
      S_PUSH: begin
        result_d = din_q;
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      depth_q  <= 6'd0;
      result_q <= '0;
      din_q    <= '0;
    end else begin
      state_q  <= state_d;
      depth_q  <= depth_d;
      result_q <= result_d;
      din_q    <= din_d;
    end
  end

  // Operand/opcode holding registers need no reset: they are always written
  // before being used.
  always_ff @(posedge clk) begin
    opc_q <= opc_d;
    a_q   <= a_d;
  end

endmodule

// File: doc/stack_sequencer.md
STACK_SEQUENCER -- requirements
Module: stack_sequencer

Interface
REQ-001 SHALL have one clock and a reset that is synchronous and active-high; no other clock or reset.
REQ-002 Port: clk  in  1  rising-edge clock, the only clock.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Port: op_valid  in  1  operation request.
REQ-005 Port: op_code  in  3  000 PUSH, 001 POP, 010 TOS, 011 ADD, 100 SUB, 101 AND, 110 NOT, 111 DUP.
REQ-006 Port: op_data  in  8  immediate for PUSH; ignored otherwise.
REQ-007 Port: op_ready  out  1  high only in IDLE.
REQ-008 Port: done  out  1  one-cycle completion pulse, registered.
REQ-009 Port: err  out  1  valid with done; 1 means rejected operation.
REQ-010 Port: result  out  8  registered, updated at done when err=0.
REQ-011 Port: stk_push / stk_pop / stk_tos  out  1 each  strobes to the 32-entry stack; at most one high per cycle.
REQ-012 Port: stk_din  out  8  push data, driven from a register.
REQ-013 Port: stk_dout  in  8  stack read data, valid the cycle after a pop or tos strobe.

Function
REQ-014 SHALL accept an operation on a rising edge with op_valid=1 and op_ready=1 (cycle T); op_code/op_data are latched at that edge.
REQ-015 SHALL keep a 6-bit depth counter, range 0..32: +1 per push strobe, -1 per pop strobe, unchanged on tos.
REQ-016 Underflow check at acceptance: PUSH needs depth>=0; POP/TOS/NOT/DUP need depth>=1; ADD/SUB/AND need depth>=2.
REQ-017 Overflow check at acceptance: PUSH and DUP need depth<=31.
REQ-018 A failing check SHALL issue no strobe, leave depth unchanged, and pulse done=1 with err=1 at T+1; result keeps its value.
REQ-019 FSM states: IDLE, POP_A, CAP_A, CAP_B, TOS_RD, TOS_CAP, PUSH, DONE, ERR.
REQ-020 PUSH sequence: stk_push=1 with stk_din=op_data at T+1; done at T+2; result=op_data.
REQ-021 POP sequence: stk_pop at T+1; stk_dout captured at T+2; done at T+3; result=popped value.
REQ-022 TOS sequence: stk_tos at T+1; capture at T+2; done at T+3; result=top value; depth unchanged.
REQ-023 Binary ops (ADD/SUB/AND) sequence:
- pop at T+1
- capture a and pop again at T+2
- capture b and compute at T+3
- push at T+4
- done at T+5
REQ-024 Binary-op arithmetic:
- ADD = b+a mod 256; SUB = b-a mod 256; AND = b&a.
- The result is pushed and presented on result.
- Net depth change -1.
REQ-025 NOT sequence: pop at T+1; capture at T+2; push ~a at T+3; done at T+4; net depth 0.
REQ-026 DUP sequence: tos at T+1; capture at T+2; push the same value at T+3; done at T+4; net depth +1.
REQ-027 From done assertion SHALL return to IDLE with op_ready=1 in the next cycle; back-to-back operations are allowed with one idle cycle between them.
REQ-028 While busy, op_valid SHALL be ignored; no queuing.
REQ-029 At depth 32 the stack pointer wraps; the overflow check SHALL prevent any push at depth 32.

Reset
REQ-030 On rst=1 at a rising edge, the next cycle SHALL show:
- state IDLE, depth 0
- all strobes 0, done=0, err=0
- result=0, stk_din=0, op_ready=1
REQ-031 rst SHALL take priority over any in-flight sequence; a partially executed operation is abandoned with no further strobes and no done.
REQ-032 Clearing the stack storage is outside this block; after rst, depth 0 defines the empty condition.

Verification
REQ-033 After reset: PUSH 0x05, PUSH 0x03, SUB -> done with err=0 at T+5, result=0x02, depth=1, strobes pop, pop, push in order.
REQ-034 After reset: POP -> done=1, err=1 at T+1, no strobe, depth=0; then ADD with depth=1 -> err=1.
REQ-035 After 32 PUSHes -> depth 32; the 33rd PUSH and a DUP -> err=1, no stk_push.
REQ-036 PUSH 0xF0, PUSH 0x20, ADD -> result 0x10 (wrap); NOT -> result 0xEF; DUP then TOS -> result 0xEF, depth 2.
REQ-037 rst asserted at T+2 of ADD -> no push strobe and no done afterwards; op_ready=1, depth=0 the cycle after.
REQ-038 Random op stream vs. a reference LIFO model -> result and err match, and at most one strobe is high in any cycle.
